// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and types for the FIR coefficient loader
package fir_pkg;

  localparam int WIDTH = 32;
  localparam int ORDER = 8;
  localparam int IDX_W = $clog2(ORDER);

  typedef logic signed [WIDTH-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PENDING
  } loader_state_t;

endpackage

// File: rtl/fir_coeff_bank.sv
// rtl/fir_coeff_bank.sv - order x width coefficient register file with flattened read
module fir_coeff_bank #(
  parameter int width = 32,
  parameter int order = 8,
  parameter int idx_w = 3
) (
  input  logic                   clk,
  input  logic                   clear_i,
  input  logic                   we_i,
  input  logic [idx_w-1:0]       idx_i,
  input  logic [width-1:0]       data_i,
  output logic [order*width-1:0] flat_o
);

  logic [width-1:0] mem_q [order];

  always_ff @(posedge clk) begin
    for (int j = 0; j < order; j++) begin
      if (clear_i) begin
        mem_q[j] <= '0;
      end else if (we_i && (idx_i == idx_w'(j))) begin
        mem_q[j] <= data_i;
      end
    end
  end

  always_comb begin
    flat_o = '0;
    for (int j = 0; j < order; j++) begin
      flat_o[j*width +: width] = mem_q[j];
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - double-buffered coefficient loader with sample-boundary swap
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int order = ORDER
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      coeff_valid,
  output logic                      coeff_ready,
  input  logic signed [width-1:0]   coeff_data,
  input  logic                      coeff_last,
  input  logic                      sample_strobe,
  output logic [order*width-1:0]    coeffs_out,
  output logic                      active_bank,
  output logic                      swap_done,
  output logic                      load_error,
  output logic                      busy
);

  localparam int IdxW = $clog2(order);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(order - 1);

  loader_state_t   state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            active_q, active_d;
  logic            swap_q, swap_d;
  logic            err_q, err_d;

  logic                   xfer;
  logic [order*width-1:0] flat0, flat1;

  assign coeff_ready = ~reset & (state_q != PENDING);
  assign xfer        = coeff_valid & coeff_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    active_d = active_q;
    swap_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (coeff_last) begin
            err_d = 1'b1;
          end else begin
            idx_d   = IdxW'(1);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          // Any set whose last flag disagrees with its length is thrown away.
          if ((idx_q == LastIdx) != coeff_last) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else if (coeff_last) begin
            idx_d   = '0;
            state_d = PENDING;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      PENDING: begin
        if (sample_strobe) begin
          active_d = ~active_q;
          swap_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      active_q <= 1'b0;
      swap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      swap_q   <= swap_d;
      err_q    <= err_d;
    end
  end

  // Writes always land in the bank the filter is not reading.
  fir_coeff_bank #(.width(width), .order(order), .idx_w(IdxW)) u_bank0 (
    .clk    (clk),
    .clear_i(reset),
    .we_i   (xfer & active_q),
    .idx_i  (idx_q),
    .data_i (coeff_data),
    .flat_o (flat0)
  );

  fir_coeff_bank #(.width(width), .order(order), .idx_w(IdxW)) u_bank1 (
    .clk    (clk),
    .clear_i(reset),
    .we_i   (xfer & ~active_q),
    .idx_i  (idx_q),
    .data_i (coeff_data),
    .flat_o (flat1)
  );

  assign coeffs_out  = active_q ? flat1 : flat0;
  assign active_bank = active_q;
  assign swap_done   = swap_q;
  assign load_error  = err_q;
  assign busy        = (state_q == LOAD) || (state_q == PENDING);

endmodule
